// File: rtl/dmem_if.sv
// Core <-> data-memory request/response bundle.
// The core drives requests through the master modport; the memory responds through the slave modport.
interface dmem_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] address;
    logic              read_enable;
    logic              write_enable;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              stall;

    modport master (
        output address, read_enable, write_enable, write_data,
        input  read_data, stall
    );

    modport slave (
        input  address, read_enable, write_enable, write_data,
        output read_data, stall
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// Word-addressed data memory with a FIFO store buffer that drains into the array on idle port cycles.
// Optional macro DMEM_FORWARD_EN: loads forward from buffered stores instead of waiting for the drain.
module dmem_store_buffer #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_WORDS = 1024,
    parameter int SB_DEPTH  = 4
) (
    input logic   clk,
    input logic   reset,
    dmem_if.slave bus
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem     [MEM_WORDS];
    logic [IDX_W-1:0]  sb_idx  [SB_DEPTH];
    logic [DATA_W-1:0] sb_data [SB_DEPTH];

    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] read_data_q;
    logic [DATA_W-1:0] rd_val;
    logic [IDX_W-1:0]  idx;
    logic              full, hazard, stall, wr_acc, rd_acc, drain;

    // Byte offset and bits above the index field do not select a word.
    logic unused_addr;
    assign unused_addr = ^{bus.address[2:0], bus.address[ADDR_W-1:IDX_W+3]};

    assign idx    = bus.address[3 +: IDX_W];
    assign full   = (count == CNT_W'(SB_DEPTH));
    assign stall  = (bus.write_enable & full) | (bus.read_enable & ~bus.write_enable & hazard);
    assign wr_acc = bus.write_enable & ~full;
    assign rd_acc = bus.read_enable & ~bus.write_enable & ~hazard;
    assign drain  = (count != '0) & ~wr_acc & ~rd_acc;

`ifdef DMEM_FORWARD_EN
    assign hazard = 1'b0;

    // Scan oldest to youngest so the last match (youngest store) wins.
    always_comb begin
        rd_val = mem[idx];
        for (int k = 0; k < SB_DEPTH; k++) begin
            if (k < int'(count) && sb_idx[head + PTR_W'(k)] == idx)
                rd_val = sb_data[head + PTR_W'(k)];
        end
    end
`else
    assign hazard = (count != '0);
    assign rd_val = mem[idx];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            read_data_q <= '0;
        end else begin
            if (wr_acc) begin
                tail  <= tail + PTR_W'(1);
                count <= count + CNT_W'(1);
            end else if (drain) begin
                head  <= head + PTR_W'(1);
                count <= count - CNT_W'(1);
            end
            if (rd_acc)
                read_data_q <= rd_val;
        end
    end

    // Buffer payload and array carry no reset; a reset cycle must not drain.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            sb_idx[tail]  <= idx;
            sb_data[tail] <= bus.write_data;
        end
        if (!reset && drain)
            mem[sb_idx[head]] <= sb_data[head];
    end

    assign bus.read_data = read_data_q;
    assign bus.stall     = stall;
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer; expectations follow the macro DMEM_FORWARD_EN.
module tb_dmem_store_buffer;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    dmem_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    dmem_store_buffer #(.ADDR_W(64), .DATA_W(64), .MEM_WORDS(1024), .SB_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one request, hold it while stalled (bounded), return stall-cycle count.
    task automatic xfer(input logic we, input logic re, input logic [63:0] a,
                        input logic [63:0] d, output int stalls);
        bus.write_enable = we;
        bus.read_enable  = re;
        bus.address      = a;
        bus.write_data   = d;
        stalls = 0;
        #1;
        while (bus.stall === 1'b1 && stalls < 8) begin
            stalls++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    logic [63:0] exp_data [5] = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5};
    int s;

    initial begin
        bus.address = '0; bus.write_data = '0;
        bus.write_enable = 1'b0; bus.read_enable = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // reset state
        chk("rst_rdata", bus.read_data, 64'h0);
        chk("rst_count", 64'(dut.count), 64'h0);
        chk("rst_stall", 64'(bus.stall), 64'h0);

        // 1: write, idle, read back
        xfer(1'b1, 1'b0, 64'h10, 64'hDEADBEEF, s);
        chk("t1_wr_stall", 64'(s), 64'h0);
        idle(1);
        xfer(1'b0, 1'b1, 64'h10, 64'h0, s);
        chk("t1_rd_stall", 64'(s), 64'h0);
        chk("t1_rdata", bus.read_data, 64'hDEADBEEF);
        idle(1);
        chk("t1_hold", bus.read_data, 64'hDEADBEEF);

        // 2: fill buffer, 5th write stalls exactly one cycle
        for (int i = 0; i < 5; i++) begin
            xfer(1'b1, 1'b0, 64'(i * 8), exp_data[i], s);
            chk($sformatf("t2_wr%0d_stall", i), 64'(s), (i == 4) ? 64'd1 : 64'd0);
        end
        idle(6);
        chk("t2_drained", 64'(dut.count), 64'h0);
        for (int i = 0; i < 5; i++) begin
            xfer(1'b0, 1'b1, 64'(i * 8), 64'h0, s);
            chk($sformatf("t2_rd%0d", i), bus.read_data, exp_data[i]);
        end

        // 3: read-after-write to a buffered word
        xfer(1'b1, 1'b0, 64'h40, 64'hA, s);
        xfer(1'b1, 1'b0, 64'h40, 64'hB, s);
        xfer(1'b0, 1'b1, 64'h40, 64'h0, s);
`ifdef DMEM_FORWARD_EN
        chk("t3_stall", 64'(s), 64'd0);
`else
        chk("t3_stall", 64'(s), 64'd2);
`endif
        chk("t3_rdata", bus.read_data, 64'hB);
        idle(2);

        // 4: reset discards buffered writes, array keeps drained word
        xfer(1'b1, 1'b0, 64'h80, 64'd1, s);
        idle(2);
        xfer(1'b1, 1'b0, 64'h80, 64'd2, s);
        xfer(1'b1, 1'b0, 64'h80, 64'd3, s);
        xfer(1'b1, 1'b0, 64'h80, 64'd4, s);
        chk("t4_pre_count", 64'(dut.count), 64'd3);
        do_reset();
        chk("t4_count", 64'(dut.count), 64'h0);
        chk("t4_rst_rdata", bus.read_data, 64'h0);
        xfer(1'b0, 1'b1, 64'h80, 64'h0, s);
        chk("t4_rd_stall", 64'(s), 64'h0);
        chk("t4_rdata", bus.read_data, 64'd1);

        // 5: both enables -> write only, read_data holds
        xfer(1'b1, 1'b1, 64'h18, 64'd7, s);
        chk("t5_stall", 64'(s), 64'h0);
        chk("t5_hold", bus.read_data, 64'd1);
        idle(1);
        xfer(1'b0, 1'b1, 64'h18, 64'h0, s);
        chk("t5_rdata", bus.read_data, 64'd7);

        // 6: index aliasing above MEM_WORDS*8
        xfer(1'b1, 1'b0, 64'h2008, 64'h55, s);
        idle(1);
        xfer(1'b0, 1'b1, 64'h8, 64'h0, s);
        chk("t6_alias", bus.read_data, 64'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
